// File: rtl/chaos_mon_pkg.sv
// Shared constants and helpers for the chaos checkpoint monitor.
package chaos_mon_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Fail codes reported on fail_code
  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_GTO   = 3'd1;
  localparam logic [2:0] FC_STO   = 3'd2;
  localparam logic [2:0] FC_SEQ   = 3'd3;
  localparam logic [2:0] FC_CFG   = 3'd4;
  localparam logic [2:0] FC_ABORT = 3'd5;

  // Resolve simultaneous terminating events into one fail code.
  // A final-step accept outranks every watchdog and reports no failure.
  function automatic logic [2:0] resolve_fc(input logic abort_ev,
                                            input logic final_ev,
                                            input logic gto_ev,
                                            input logic sto_ev,
                                            input logic seq_ev);
    logic [2:0] fc;
    fc = FC_NONE;
    if (abort_ev)      fc = FC_ABORT;
    else if (final_ev) fc = FC_NONE;
    else if (gto_ev)   fc = FC_GTO;
    else if (sto_ev)   fc = FC_STO;
    else if (seq_ev)   fc = FC_SEQ;
    return fc;
  endfunction

endpackage

// File: rtl/chaos_checkpoint_monitor_filter.sv
// Glitch filter: a value is stable once it has been seen on FILT
// consecutive edges (the current edge included).
module chaos_mon_filter
  import chaos_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FILT  = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] mon,
  output logic             stable_c,
  output logic             changed_c,
  output logic [WIDTH-1:0] sample_c
);

  localparam int unsigned RW = $clog2(FILT + 1);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RW-1:0]    run_q, run_d;

  // Run length including the current edge; stable is judged on that value
  always_comb begin
    prev_d    = mon;
    changed_c = (mon != prev_q);
    run_d     = run_q;
    if (changed_c) begin
      run_d = RW'(1);
    end else if (run_q < RW'(FILT)) begin
      run_d = RW'(run_q + RW'(1));
    end
    stable_c = (run_d >= RW'(FILT));
    sample_c = mon;
  end

  // Previous sample and run counter
  always_ff @(posedge clock) begin
    if (!resetb) begin
      prev_q <= '0;
      run_q  <= '0;
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/chaos_checkpoint_monitor.sv
// Checkpoint-sequence monitor: matches filtered mon values against an
// expected table in order, with global and per-step watchdogs.
module chaos_checkpoint_monitor
  import chaos_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned FILT  = 2
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     tbl_we,
  input  logic [$clog2(DEPTH)-1:0] tbl_addr,
  input  logic [WIDTH-1:0]         tbl_data,
  input  logic [$clog2(DEPTH):0]   num_steps,
  input  logic [CNT_W-1:0]         timeout,
  input  logic [CNT_W-1:0]         step_timeout,
  input  logic                     strict,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         mon,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [2:0]               fail_code,
  output logic [$clog2(DEPTH):0]   step,
  output logic [CNT_W-1:0]         elapsed,
  output logic [WIDTH-1:0]         last_val
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       fc_q, fc_d;
  logic [SW-1:0]    step_q, step_d;
  logic [SW-1:0]    nsteps_q, nsteps_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] stmr_q, stmr_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] stimeout_q, stimeout_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             strict_q, strict_d;
  logic             consumed_q, consumed_d;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] tbl_d [DEPTH];

  logic             stable_c;
  logic             changed_c;
  logic [WIDTH-1:0] sample_c;
  logic [WIDTH-1:0] exp_c;
  logic             consumed_eff_c;
  logic             acc_c;
  logic             fin_c;
  logic             gto_c;
  logic             sto_c;
  logic             seq_c;
  logic             term_c;
  logic             cfg_bad_c;

  chaos_mon_filter #(
    .WIDTH (WIDTH),
    .FILT  (FILT)
  ) u_filter (
    .clock     (clock),
    .resetb    (resetb),
    .mon       (mon),
    .stable_c  (stable_c),
    .changed_c (changed_c),
    .sample_c  (sample_c)
  );

  // Expected-table write port; locked out while a run is in progress
  always_comb begin
    tbl_d = tbl_q;
    if (tbl_we && !busy_q) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (tbl_addr == AW'(i)) tbl_d[i] = tbl_data;
      end
    end
  end

  // Match and watchdog event decode for the current edge
  always_comb begin
    exp_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (step_q == SW'(i)) exp_c = tbl_q[i];
    end
    // An accepted value must leave and return before it can be accepted again
    consumed_eff_c = consumed_q && !changed_c;
    acc_c     = stable_c && !consumed_eff_c && (sample_c == exp_c);
    fin_c     = acc_c && (SW'(step_q + SW'(1)) == nsteps_q);
    gto_c     = (timeout_q != '0) && (elapsed_q == CNT_W'(timeout_q - CNT_W'(1)));
    sto_c     = (stimeout_q != '0) && (stmr_q == CNT_W'(stimeout_q - CNT_W'(1)));
    seq_c     = strict_q && stable_c && (sample_c != exp_c) && (sample_c != last_q);
    term_c    = abort || fin_c || gto_c || sto_c || seq_c;
    cfg_bad_c = (num_steps == '0) || (num_steps > SW'(DEPTH));
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fc_d       = fc_q;
    step_d     = step_q;
    nsteps_d   = nsteps_q;
    elapsed_d  = elapsed_q;
    stmr_d     = stmr_q;
    timeout_d  = timeout_q;
    stimeout_d = stimeout_q;
    last_d     = last_q;
    strict_d   = strict_q;
    consumed_d = consumed_eff_c;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          step_d    = '0;
          elapsed_d = '0;
          pass_d    = 1'b0;
          if (cfg_bad_c) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            fc_d    = FC_CFG;
          end else begin
            state_d    = ST_WAIT;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            fc_d       = FC_NONE;
            stmr_d     = '0;
            last_d     = sample_c;
            nsteps_d   = num_steps;
            timeout_d  = timeout;
            stimeout_d = step_timeout;
            strict_d   = strict;
            consumed_d = 1'b0;
          end
        end
      end

      ST_WAIT: begin
        if (acc_c && !abort) begin
          step_d     = SW'(step_q + SW'(1));
          last_d     = sample_c;
          consumed_d = 1'b1;
        end
        if (term_c) begin
          // elapsed and the step timer freeze on the deciding edge
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = fin_c && !abort;
          fc_d    = resolve_fc(abort, fin_c, gto_c, sto_c, seq_c);
        end else begin
          elapsed_d = (elapsed_q == '1) ? elapsed_q : CNT_W'(elapsed_q + CNT_W'(1));
          if (acc_c) begin
            stmr_d = '0;
          end else begin
            stmr_d = (stmr_q == '1) ? stmr_q : CNT_W'(stmr_q + CNT_W'(1));
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, run bookkeeping and expected table
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fc_q       <= FC_NONE;
      step_q     <= '0;
      nsteps_q   <= '0;
      elapsed_q  <= '0;
      stmr_q     <= '0;
      timeout_q  <= '0;
      stimeout_q <= '0;
      last_q     <= '0;
      strict_q   <= 1'b0;
      consumed_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fc_q       <= fc_d;
      step_q     <= step_d;
      nsteps_q   <= nsteps_d;
      elapsed_q  <= elapsed_d;
      stmr_q     <= stmr_d;
      timeout_q  <= timeout_d;
      stimeout_q <= stimeout_d;
      last_q     <= last_d;
      strict_q   <= strict_d;
      consumed_q <= consumed_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fc_q;
  assign step      = step_q;
  assign elapsed   = elapsed_q;
  assign last_val  = last_q;

endmodule

// File: doc/chaos_checkpoint_monitor.md
# chaos_checkpoint_monitor

Synthesizable checkpoint-sequence monitor for the chaos automaton test harness. Watches a WIDTH-bit checkpoint bus (normally mprj_io[31:16]) for an ordered list of up to DEPTH expected values, with a glitch filter, per-step and global watchdogs, and an optional strict mode. Reports pass, fail and a fail code. It replaces ad-hoc wait-and-timeout checking so that on-chip logic and benches share one checker.

## Interface
- WIDTH, 16, checkpoint bus width
- DEPTH, 8, maximum expected-sequence length (≥2)
- CNT_W, 24, watchdog/elapsed counter width
- FILT, 2, consecutive identical samples required to accept a value (≥1)

- clock  in  1  sole clock, rising edge
- resetb  in  1  synchronous, active-low reset
- tbl_we  in  1  expected-table write strobe; ignored while busy
- tbl_addr  in  $clog2(DEPTH)  table entry index
- tbl_data  in  WIDTH  expected value
- num_steps  in  $clog2(DEPTH)+1  sequence length, legal 1..DEPTH
- timeout  in  CNT_W  global cycle budget; 0 = disabled
- step_timeout  in  CNT_W  per-step budget; 0 = disabled
- strict  in  1  fail on any unexpected stable value
- start  in  1  one-cycle run request
- abort  in  1  terminate a run
- mon  in  WIDTH  observed checkpoint bus
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  valid when done
- fail_code  out  3  0 none, 1 global timeout, 2 step timeout, 3 sequence error, 4 config error, 5 aborted
- step  out  $clog2(DEPTH)+1  steps accepted so far
- elapsed  out  CNT_W  cycles since start, saturating
- last_val  out  WIDTH  last accepted value

## Operation
- States: IDLE, WAIT, DONE. On reset, go to IDLE. All outputs are 0 on reset and the table clears to 0.
- IDLE/DONE + start: num_steps is 0 or >DEPTH → DONE with fail_code=4 on the next edge. Otherwise → WAIT with step=0, elapsed=0, step timer=0, last_val=mon, busy=1, done=0, pass=0, fail_code=0.
- start while busy is ignored. Configuration inputs are sampled only at start.
- Filter: run = number of consecutive edges on which mon is unchanged, including the current edge, saturating at FILT. A value is stable when run ≥ FILT. The filter runs continuously, including in IDLE.
- WAIT, stable and mon == table[step]: step++, last_val=mon, step timer clears. When step reaches num_steps → DONE with pass=1.
- WAIT, strict=1, stable, mon ≠ table[step] and mon ≠ last_val → DONE with fail_code=3.
- Watchdogs:
  - global: fail_code=1 when elapsed reaches timeout−1 without completion, so the run is allowed exactly `timeout` edges in WAIT.
  - per-step: same rule, with fail_code=2.
- Event priority on the same edge: abort (5) > final-step accept (pass) > global timeout (1) > step timeout (2) > sequence error (3).
- abort in IDLE/DONE has no effect. Repeated table values are legal; each needs a fresh acceptance, i.e. mon must change and return.

## Timing
- A value first presented on mon at edge t and held is accepted at edge t+FILT−1. step and last_val update on that edge.
- Completion and failure are visible one cycle after the deciding edge: done=1, busy=0.
- elapsed increments every WAIT edge and freezes in DONE.
- A table write takes effect on the edge of tbl_we.
- resetb low mid-run: next edge returns to IDLE with all outputs 0.

## Structure
- Package chaos_mon_pkg holds:
  - state enum
  - fail-code localparams (FC_NONE..FC_ABORT)
  - priority encoding helper function
- Sub-module chaos_mon_filter (WIDTH, FILT): registered previous sample plus run counter. Outputs stable and the sampled value.
- Top level holds the FSM, expected table (DEPTH×WIDTH flops), and watchdog counters.

## Test plan
- Table {AB40, AB41, AB51}, num_steps=3, FILT=2, timeout=0. Drive each value for 3 cycles → pass=1, step=3, last_val=AB51, fail_code=0.
- Same sequence with a 1-cycle AB51 glitch between AB40 and AB41, strict=0 → glitch ignored, pass=1.
- Same glitch held 2 cycles with strict=1 → fail_code=3, step=1.
- timeout=200000, mon stuck at AB40 → fail_code=1 exactly 200000 WAIT edges after start, elapsed=199999.
- step_timeout=50, timeout=50; final value accepted on the edge the watchdogs expire → pass=1. Separately, no accept → fail_code=1, not 2.
- num_steps=0 → fail_code=4 one edge after start. Then abort mid-run gives fail_code=5, and resetb low mid-run clears busy, step and elapsed to 0.
